// File: rtl/route_pkg.sv
// Shared codes for the torus route-computation stage: port/direction codes,
// flit-type codes, dimension indices and the packet-tracking state.
package route_pkg;

    // Port / direction codes (arrival port on dir_in, routed port on dir_out)
    localparam logic [2:0] DIR_INJECT = 3'd0;
    localparam logic [2:0] DIR_XPOS   = 3'd1;
    localparam logic [2:0] DIR_YPOS   = 3'd2;
    localparam logic [2:0] DIR_ZPOS   = 3'd3;
    localparam logic [2:0] DIR_XNEG   = 3'd4;
    localparam logic [2:0] DIR_YNEG   = 3'd5;
    localparam logic [2:0] DIR_ZNEG   = 3'd6;
    localparam logic [2:0] DIR_EJECT  = 3'd7;

    // Dimension indices; DIM_NONE marks inject/eject, which belong to no dimension
    localparam logic [1:0] DIM_X    = 2'd0;
    localparam logic [1:0] DIM_Y    = 2'd1;
    localparam logic [1:0] DIM_Z    = 2'd2;
    localparam logic [1:0] DIM_NONE = 2'd3;

    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_HEAD   = 2'b01,
        FT_BODY   = 2'b10,
        FT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_state_e;

    // Dimension a port belongs to (XPOS/XNEG -> X, ...)
    function automatic logic [1:0] dim_of_dir(input logic [2:0] dir);
        logic [1:0] dim;
        dim = DIM_NONE;
        case (dir)
            DIR_XPOS, DIR_XNEG: dim = DIM_X;
            DIR_YPOS, DIR_YNEG: dim = DIM_Y;
            DIR_ZPOS, DIR_ZNEG: dim = DIM_Z;
            default:            dim = DIM_NONE;
        endcase
        return dim;
    endfunction

    // Direction code for a dimension and sign
    function automatic logic [2:0] dir_of_dim(input logic [1:0] dim, input logic pos);
        return pos ? (3'd1 + {1'b0, dim}) : (3'd4 + {1'b0, dim});
    endfunction

endpackage

// File: rtl/torus_dim_route.sv
// One torus dimension: is it resolved, which way is shortest (tie goes
// positive), how many hops remain, and does the first hop cross the dateline.
module torus_dim_route #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned CUR     = 0,
    parameter int unsigned COORD_W = 3
) (
    input  logic [COORD_W-1:0] dst,
    output logic               resolved,
    output logic               pos,
    output logic [COORD_W:0]   hops,
    output logic               crosses_dateline
);
    import route_pkg::*;

    localparam int unsigned W1 = COORD_W + 1;
    localparam logic [COORD_W:0] SIZE_V = W1'(SIZE);
    localparam logic [COORD_W:0] CUR_V  = W1'(CUR);
    localparam logic [COORD_W:0] HALF_V = W1'(SIZE / 2);
    localparam logic [COORD_W:0] LAST_V = W1'(SIZE - 1);

    logic [COORD_W:0] dst_e;
    logic [COORD_W:0] abs_diff;
    logic [COORD_W:0] wrap_dist;
    logic             ahead;

    // Shortest-way decision for this dimension
    always_comb begin
        dst_e     = {1'b0, dst};
        ahead     = (dst_e > CUR_V);
        abs_diff  = ahead ? (dst_e - CUR_V) : (CUR_V - dst_e);
        wrap_dist = SIZE_V - abs_diff;
        resolved  = (dst_e == CUR_V);
        // Forward: go positive up to half way. Backward: going positive
        // round the ring is as short or shorter once |diff| reaches half.
        pos       = ahead ? (abs_diff <= HALF_V) : (abs_diff >= HALF_V);
        hops      = (abs_diff < wrap_dist) ? abs_diff : wrap_dist;
        // The wrap link sits between SIZE-1 and 0
        crosses_dateline = !resolved && (pos ? (CUR_V == LAST_V) : (CUR_V == '0));
    end

endmodule

// File: rtl/route_comp_torus.sv
// Route-computation stage for one router input port. Heads/singles are routed
// (dimension order per DIM_ORDER), get their VC class and farthest-first
// priority rewritten; body/tail follow the direction latched from the head.
// Handshake: a flit moves in when in_valid && in_ready; the registered output
// is held until out_ready, and a new flit may enter in the same cycle the
// current one leaves.
module route_comp_torus #(
    parameter int unsigned CUR_X     = 0,
    parameter int unsigned CUR_Y     = 0,
    parameter int unsigned CUR_Z     = 0,
    parameter int unsigned XSIZE     = 4,
    parameter int unsigned YSIZE     = 4,
    parameter int unsigned ZSIZE     = 4,
    parameter int unsigned COORD_W   = 3,
    parameter int unsigned FLIT_W    = 85,
    parameter int unsigned DST_POS   = 72,
    parameter int unsigned CMP_POS   = 64,
    parameter int unsigned CMP_W     = 8,
    parameter int unsigned VC_POS    = 82,
    parameter int unsigned TYPE_POS  = 83,
    parameter int unsigned DIM_ORDER = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic [2:0]        dir_in,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid_out,
    output logic              eject_enable,
    output logic [2:0]        dir_out,
    output logic              err_orphan,
    output logic              err_nested
);
    import route_pkg::*;

    localparam logic [31:0] CMP_MAX = 32'((64'd1 << CMP_W) - 64'd1);

    logic [COORD_W:0] hops_v [3];
    logic             res_v  [3];
    logic             pos_v  [3];
    logic             crs_v  [3];

    torus_dim_route #(.SIZE(XSIZE), .CUR(CUR_X), .COORD_W(COORD_W)) u_dim_x (
        .dst(flit_in[DST_POS +: COORD_W]), .resolved(res_v[0]), .pos(pos_v[0]),
        .hops(hops_v[0]), .crosses_dateline(crs_v[0]));
    torus_dim_route #(.SIZE(YSIZE), .CUR(CUR_Y), .COORD_W(COORD_W)) u_dim_y (
        .dst(flit_in[DST_POS + COORD_W +: COORD_W]), .resolved(res_v[1]), .pos(pos_v[1]),
        .hops(hops_v[1]), .crosses_dateline(crs_v[1]));
    torus_dim_route #(.SIZE(ZSIZE), .CUR(CUR_Z), .COORD_W(COORD_W)) u_dim_z (
        .dst(flit_in[DST_POS + 2*COORD_W +: COORD_W]), .resolved(res_v[2]), .pos(pos_v[2]),
        .hops(hops_v[2]), .crosses_dateline(crs_v[2]));

    // k-th dimension visited under the configured order
    function automatic int dim_sel(input int k);
        return (DIM_ORDER == 1) ? (2 - k) : k;
    endfunction

    pkt_state_e        state_q, state_d;
    logic [2:0]        dir_hold_q, dir_hold_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic [2:0]        dir_q, dir_d;
    logic              fv_q, fv_d;
    logic              ej_q, ej_d;
    logic              orphan_q, orphan_d;
    logic              nested_q, nested_d;

    logic [2:0]        route_dir;
    logic [1:0]        route_dim;
    logic              route_cross;
    logic              found;
    logic              vc_new;
    logic [31:0]       hop_sum;
    logic [CMP_W-1:0]  cmp_new;
    logic [FLIT_W-1:0] head_flit;
    flit_type_e        ftype;
    logic              xfer;

    assign in_ready = ~(fv_q | ej_q) | out_ready;
    assign xfer     = in_valid & in_ready;
    assign ftype    = flit_type_e'(flit_in[TYPE_POS +: 2]);

    // Route, VC class and priority for a head/single flit
    always_comb begin
        route_dir   = DIR_EJECT;
        route_dim   = DIM_NONE;
        route_cross = 1'b0;
        found       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && !res_v[dim_sel(k)]) begin
                found       = 1'b1;
                route_dim   = 2'(dim_sel(k));
                route_cross = crs_v[dim_sel(k)];
                route_dir   = dir_of_dim(2'(dim_sel(k)), pos_v[dim_sel(k)]);
            end
        end

        // Dateline crossing forces class 1; entering a new dimension (or the
        // network) restarts at class 0; otherwise keep the incoming class.
        vc_new = flit_in[VC_POS];
        if (route_dir != DIR_EJECT) begin
            if (route_cross)
                vc_new = 1'b1;
            else if (dir_in == DIR_INJECT || dim_of_dir(dir_in) != route_dim)
                vc_new = 1'b0;
        end

        hop_sum = 32'(hops_v[0]) + 32'(hops_v[1]) + 32'(hops_v[2]);
        cmp_new = (hop_sum > CMP_MAX) ? '1 : hop_sum[CMP_W-1:0];

        head_flit = flit_in;
        head_flit[VC_POS] = vc_new;
        head_flit[CMP_POS +: CMP_W] = cmp_new;
    end

    // Packet FSM, output register load/drain and sticky error flags
    always_comb begin
        state_d    = state_q;
        dir_hold_d = dir_hold_q;
        flit_d     = flit_q;
        dir_d      = dir_q;
        fv_d       = fv_q;
        ej_d       = ej_q;
        orphan_d   = orphan_q;
        nested_d   = nested_q;

        if (xfer) begin
            fv_d = 1'b0;
            ej_d = 1'b0;
            case (ftype)
                FT_SINGLE, FT_HEAD: begin
                    if (state_q == ST_PKT)
                        nested_d = 1'b1;
                    flit_d = head_flit;
                    dir_d  = route_dir;
                    fv_d   = (route_dir != DIR_EJECT);
                    ej_d   = (route_dir == DIR_EJECT);
                    if (ftype == FT_HEAD) begin
                        state_d    = ST_PKT;
                        dir_hold_d = route_dir;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    if (state_q == ST_IDLE) begin
                        // No open packet: nowhere to send it, so it is dropped
                        orphan_d = 1'b1;
                    end else begin
                        flit_d = flit_in;
                        dir_d  = dir_hold_q;
                        fv_d   = (dir_hold_q != DIR_EJECT);
                        ej_d   = (dir_hold_q == DIR_EJECT);
                        if (ftype == FT_TAIL)
                            state_d = ST_IDLE;
                    end
                end
            endcase
        end else if (out_ready) begin
            fv_d = 1'b0;
            ej_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_hold_q <= '0;
            flit_q     <= '0;
            dir_q      <= '0;
            fv_q       <= 1'b0;
            ej_q       <= 1'b0;
            orphan_q   <= 1'b0;
            nested_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_hold_q <= dir_hold_d;
            flit_q     <= flit_d;
            dir_q      <= dir_d;
            fv_q       <= fv_d;
            ej_q       <= ej_d;
            orphan_q   <= orphan_d;
            nested_q   <= nested_d;
        end
    end

    assign flit_out       = flit_q;
    assign dir_out        = dir_q;
    assign flit_valid_out = fv_q;
    assign eject_enable   = ej_q;
    assign err_orphan     = orphan_q;
    assign err_nested     = nested_q;

endmodule

// File: tb/tb_route_comp_torus.sv
// Directed bench for route_comp_torus: three instances share the input
// stream (X-first at origin, Z-first at origin, X-first at (3,3,3) with a
// 2-bit priority field) and each step checks hand-computed results.
module tb_route_comp_torus;

    localparam int FW = 85;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [FW-1:0] flit_in;
    logic [2:0]    dir_in;
    logic          out_ready;

    logic          a_in_ready, a_fv, a_ej, a_orphan, a_nested;
    logic [FW-1:0] a_flit;
    logic [2:0]    a_dir;
    logic          z_in_ready, z_fv, z_ej, z_orphan, z_nested;
    logic [FW-1:0] z_flit;
    logic [2:0]    z_dir;
    logic          c_in_ready, c_fv, c_ej, c_orphan, c_nested;
    logic [FW-1:0] c_flit;
    logic [2:0]    c_dir;

    int n_cmp = 0;
    int n_err = 0;

    route_comp_torus dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .flit_in(flit_in), .dir_in(dir_in), .out_ready(out_ready),
        .flit_out(a_flit), .flit_valid_out(a_fv), .eject_enable(a_ej),
        .dir_out(a_dir), .err_orphan(a_orphan), .err_nested(a_nested));

    route_comp_torus #(.DIM_ORDER(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .flit_in(flit_in), .dir_in(dir_in), .out_ready(out_ready),
        .flit_out(z_flit), .flit_valid_out(z_fv), .eject_enable(z_ej),
        .dir_out(z_dir), .err_orphan(z_orphan), .err_nested(z_nested));

    route_comp_torus #(.CUR_X(3), .CUR_Y(3), .CUR_Z(3), .CMP_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .flit_in(flit_in), .dir_in(dir_in), .out_ready(out_ready),
        .flit_out(c_flit), .flit_valid_out(c_fv), .eject_enable(c_ej),
        .dir_out(c_dir), .err_orphan(c_orphan), .err_nested(c_nested));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit builder: {type, vc, unused, z, y, x, cmp, payload}
    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic vc,
                                         input logic [2:0] z, input logic [2:0] y,
                                         input logic [2:0] x, input logic [7:0] cmp,
                                         input logic [63:0] pay);
        logic [FW-1:0] f;
        f = '0;
        f[63:0]  = pay;
        f[71:64] = cmp;
        f[74:72] = x;
        f[77:75] = y;
        f[80:78] = z;
        f[82]    = vc;
        f[84:83] = t;
        return f;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [FW-1:0] f, input logic [2:0] d);
        in_valid = 1'b1;
        flit_in  = f;
        dir_in   = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flit_in  = '0;
        dir_in   = 3'd0;
    endtask

    logic [63:0]   p;
    logic [FW-1:0] f_in, f_exp, f_b, f_t, f_h;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        #2;
        chk("reset_fv",     FW'(a_fv), FW'(0));
        chk("reset_ej",     FW'(a_ej), FW'(0));
        chk("reset_dir",    FW'(a_dir), FW'(0));
        chk("reset_flit",   a_flit, '0);
        chk("reset_orphan", FW'(a_orphan), FW'(0));
        chk("reset_nested", FW'(a_nested), FW'(0));
        chk("reset_ready",  FW'(a_in_ready), FW'(1));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single to (3,0,0) from inject: XNEG across the dateline
        p = rnd64();
        drive(mk(2'b00, 1'b0, 3'd0, 3'd0, 3'd3, 8'h55, p), 3'd0);
        #2;
        chk("single_pre_fv", FW'(a_fv), FW'(0));
        tick();
        idle();
        chk("single_fv",   FW'(a_fv), FW'(1));
        chk("single_ej",   FW'(a_ej), FW'(0));
        chk("single_dir",  FW'(a_dir), FW'(4));
        chk("single_flit", a_flit, mk(2'b00, 1'b1, 3'd0, 3'd0, 3'd3, 8'h01, p));
        tick();
        chk("single_drain_fv", FW'(a_fv), FW'(0));

        // Head to (2,1,0): x tie -> XPOS, priority 3; body and tail follow
        p = rnd64();
        drive(mk(2'b01, 1'b0, 3'd0, 3'd1, 3'd2, 8'hFF, p), 3'd0);
        tick();
        chk("head_dir",  FW'(a_dir), FW'(1));
        chk("head_flit", a_flit, mk(2'b01, 1'b0, 3'd0, 3'd1, 3'd2, 8'h03, p));
        f_b = mk(2'b10, 1'b1, 3'd5, 3'd6, 3'd7, 8'hAB, rnd64());
        drive(f_b, 3'd0);
        tick();
        chk("body_dir",  FW'(a_dir), FW'(1));
        chk("body_flit", a_flit, f_b);
        chk("body_fv",   FW'(a_fv), FW'(1));
        f_t = mk(2'b11, 1'b0, 3'd3, 3'd3, 3'd3, 8'h12, rnd64());
        drive(f_t, 3'd0);
        tick();
        chk("tail_dir",  FW'(a_dir), FW'(1));
        chk("tail_flit", a_flit, f_t);

        // Body with no open packet (FSM back in IDLE): dropped, orphan flag
        drive(mk(2'b10, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, rnd64()), 3'd0);
        tick();
        idle();
        chk("orphan_flag", FW'(a_orphan), FW'(1));
        chk("orphan_fv",   FW'(a_fv), FW'(0));
        chk("orphan_ej",   FW'(a_ej), FW'(0));
        chk("orphan_nested", FW'(a_nested), FW'(0));

        // Local destination: eject, VC bit untouched, priority 0
        p = rnd64();
        drive(mk(2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 8'h77, p), 3'd3);
        tick();
        chk("eject_ej",   FW'(a_ej), FW'(1));
        chk("eject_fv",   FW'(a_fv), FW'(0));
        chk("eject_dir",  FW'(a_dir), FW'(7));
        chk("eject_flit", a_flit, mk(2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 8'h00, p));

        // Dimension order: dst (1,0,2); Z-first picks ZPOS, X-first picks XPOS
        p = rnd64();
        drive(mk(2'b00, 1'b0, 3'd2, 3'd0, 3'd1, 8'h00, p), 3'd0);
        tick();
        idle();
        chk("zfirst_dir",  FW'(z_dir), FW'(3));
        chk("zfirst_flit", z_flit, mk(2'b00, 1'b0, 3'd2, 3'd0, 3'd1, 8'h03, p));
        chk("xfirst_dir",  FW'(a_dir), FW'(1));
        tick();

        // Backpressure: head accepted, then 3 stalled cycles with body waiting
        out_ready = 1'b0;
        p   = rnd64();
        f_h = mk(2'b01, 1'b0, 3'd0, 3'd0, 3'd1, 8'h00, p);
        f_exp = mk(2'b01, 1'b0, 3'd0, 3'd0, 3'd1, 8'h01, p);
        drive(f_h, 3'd0);
        tick();
        chk("bp_head_fv",    FW'(a_fv), FW'(1));
        chk("bp_head_ready", FW'(a_in_ready), FW'(0));
        f_b = mk(2'b10, 1'b0, 3'd2, 3'd2, 3'd2, 8'h44, rnd64());
        drive(f_b, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", FW'(a_in_ready), FW'(0));
            chk("bp_stall_flit",  a_flit, f_exp);
            chk("bp_stall_dir",   FW'(a_dir), FW'(1));
            chk("bp_stall_fv",    FW'(a_fv), FW'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", FW'(a_in_ready), FW'(1));
        tick();
        chk("bp_body_flit", a_flit, f_b);
        chk("bp_body_dir",  FW'(a_dir), FW'(1));
        f_t = mk(2'b11, 1'b1, 3'd4, 3'd4, 3'd4, 8'h99, rnd64());
        drive(f_t, 3'd0);
        tick();
        idle();
        chk("bp_tail_flit", a_flit, f_t);
        chk("bp_tail_fv",   FW'(a_fv), FW'(1));
        tick();
        chk("bp_drain_fv",  FW'(a_fv), FW'(0));

        // Head inside an open packet: nested flag, second head routed and held
        drive(mk(2'b01, 1'b0, 3'd0, 3'd0, 3'd1, 8'h00, rnd64()), 3'd0);
        tick();
        chk("nest_first_flag", FW'(a_nested), FW'(0));
        chk("nest_first_dir",  FW'(a_dir), FW'(1));
        p = rnd64();
        drive(mk(2'b01, 1'b0, 3'd0, 3'd2, 3'd0, 8'h00, p), 3'd0);
        tick();
        chk("nest_flag",   FW'(a_nested), FW'(1));
        chk("nest_dir",    FW'(a_dir), FW'(2));
        chk("nest_flit",   a_flit, mk(2'b01, 1'b0, 3'd0, 3'd2, 3'd0, 8'h02, p));
        f_t = mk(2'b11, 1'b0, 3'd7, 3'd7, 3'd7, 8'h00, rnd64());
        drive(f_t, 3'd0);
        tick();
        idle();
        chk("nest_tail_dir", FW'(a_dir), FW'(2));

        // Reset mid-packet clears everything at once; the tail is then an orphan
        drive(mk(2'b01, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00, rnd64()), 3'd0);
        tick();
        idle();
        chk("mid_head_dir", FW'(a_dir), FW'(4));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fv",     FW'(a_fv), FW'(0));
        chk("mid_rst_dir",    FW'(a_dir), FW'(0));
        chk("mid_rst_flit",   a_flit, '0);
        chk("mid_rst_orphan", FW'(a_orphan), FW'(0));
        chk("mid_rst_nested", FW'(a_nested), FW'(0));
        #3;
        rst_n = 1'b1;
        tick();
        drive(mk(2'b11, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00, rnd64()), 3'd0);
        tick();
        idle();
        chk("post_rst_orphan", FW'(a_orphan), FW'(1));
        chk("post_rst_fv",     FW'(a_fv), FW'(0));

        // Node (3,3,3): backward tie goes POS across the dateline; 2-bit
        // priority saturates (2+2+2 -> 3)
        p = rnd64();
        drive(mk(2'b00, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, p), 3'd0);
        tick();
        chk("c_sat_dir",  FW'(c_dir), FW'(1));
        chk("c_sat_flit", c_flit, mk(2'b00, 1'b1, 3'd1, 3'd1, 3'd1, 8'h03, p));
        // Same dimension as arrival, no crossing: VC class inherited
        p = rnd64();
        drive(mk(2'b00, 1'b1, 3'd3, 3'd3, 3'd2, 8'h00, p), 3'd1);
        tick();
        chk("c_inherit_dir",  FW'(c_dir), FW'(4));
        chk("c_inherit_flit", c_flit, mk(2'b00, 1'b1, 3'd3, 3'd3, 3'd2, 8'h01, p));
        // Arrived on Y, turning into X: class restarts at 0
        drive(mk(2'b00, 1'b1, 3'd3, 3'd3, 3'd2, 8'h00, p), 3'd2);
        tick();
        idle();
        chk("c_turn_flit", c_flit, mk(2'b00, 1'b0, 3'd3, 3'd3, 3'd2, 8'h01, p));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/route_comp_torus.md
Name: route_comp_torus

Overview:
- Parametrised route-computation stage for the 3D-torus collective router; one instance per input port, placed between the input buffer and the VC/switch allocators.
- On each head flit it computes the output direction (dimension order selectable), dateline VC class and farthest-first priority. It holds that direction for the packet's body and tail flits.
- Single register stage with valid/ready backpressure. Local-destination packets are steered to the eject port.

Parameters:
CUR_X, 0, this node's x coordinate (CUR_Y, CUR_Z likewise, default 0)
XSIZE, 4, torus x dimension, 2..2**COORD_W (YSIZE, ZSIZE likewise, default 4)
COORD_W, 3, bits per destination coordinate
FLIT_W, 85, total flit width
DST_POS, 72, LSB of destination field {z,y,x}, 3*COORD_W bits
CMP_POS, 64, LSB of priority field
CMP_W, 8, priority field width
VC_POS, 82, VC-class bit position (head flit only)
TYPE_POS, 83, LSB of 2-bit flit type: 00 single, 01 head, 10 body, 11 tail
DIM_ORDER, 0, 0 = X then Y then Z; 1 = Z then Y then X

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input flit valid
in_ready  out  1  stage can accept a flit
flit_in  in  FLIT_W  incoming flit
dir_in  in  3  port the flit arrived on (0 inject, 1..6 XPOS,YPOS,ZPOS,XNEG,YNEG,ZNEG)
out_ready  in  1  downstream accept, used for both forward and eject
flit_out  out  FLIT_W  flit with VC and priority fields rewritten
flit_valid_out  out  1  registered flit valid, direction not eject
eject_enable  out  1  registered flit valid, direction eject
dir_out  out  3  routed direction, 7 = eject
err_orphan  out  1  sticky: body/tail arrived with no open packet
err_nested  out  1  sticky: head/single arrived inside an open packet

Behaviour:
- Reset: all outputs 0, FSM in IDLE, held dir 0, held VC 0. Reset is asynchronous and may assert mid-packet; afterwards the FSM is IDLE and any in-flight flit is lost.
- Transfer occurs when in_valid and in_ready. in_ready = ~(flit_valid_out | eject_enable) | out_ready. Latency is 1 cycle. Output registers hold their values while stalled.
- Route, per dimension d: diff = dst - cur.
  - diff = 0: dimension resolved.
  - 0 < diff <= SIZE/2, or diff < 0 with |diff| >= SIZE/2: POS.
  - Otherwise: NEG.
  - The tie at SIZE/2 resolves to POS.
  - The first unresolved dimension in DIM_ORDER gives the direction. All dimensions resolved gives 7 (eject).
- VC class (head/single only):
  - 0 if dir_in = 0, or if the routed dimension differs from dir_in's dimension.
  - 1 if the hop crosses the dateline: POS from coordinate SIZE-1, or NEG from 0.
  - Otherwise inherited from flit_in[VC_POS].
  - Eject leaves the bit unchanged.
- Priority: CMP field = sum over dimensions of min(|diff|, SIZE-|diff|), zero-extended; saturates at 2**CMP_W-1.
- FSM:
  - IDLE + head: latch dir/VC, go to PKT.
  - IDLE + single: route, stay IDLE.
  - PKT + body: use held dir, flit passes unmodified.
  - PKT + tail: use held dir, go to IDLE.
  - IDLE + body/tail: set err_orphan, accept and drop the flit (no output valid).
  - PKT + head/single: set err_nested, treat as a new head/single.
- Only accepted flits change FSM state.
- Error flags clear only on reset.

Decomposition:
- Package route_pkg holds direction codes, flit-type codes and dimension indices.
- Sub-module torus_dim_route (parameters SIZE, CUR, COORD_W) is instantiated three times; outputs resolved, pos, hops, crosses_dateline.

Test Plan:
- CUR=(0,0,0), 4x4x4, single flit to (3,0,0) from inject -> dir_out=4 XNEG, VC=1 (dateline), CMP=1, flit_valid_out=1 one cycle later.
- Head to (2,1,0) from inject -> dir 1 XPOS (tie), CMP=3; body then tail -> dir_out=1 for each, FSM back to IDLE.
- Single to (0,0,0) -> eject_enable=1, flit_valid_out=0, dir_out=7; DIM_ORDER=1 with dst (1,0,2) -> dir 3 ZPOS.
- out_ready=0 for 3 cycles with stream head/body/tail -> in_ready=0 after the first flit; outputs stable, no flit lost or duplicated.
- Body with FSM IDLE -> err_orphan=1, no output valid; head,head -> err_nested=1, second head routed.
- rst_n asserted between head and tail -> outputs 0 immediately; tail afterward raises err_orphan.
